// File: rtl/pipeline_ctrl.sv
// Hazard/forwarding control and E/M/W control-stage registers for a 5-stage RISC pipeline.
// Stalls/flushes/forwards are combinational and the W/M outputs are registered; define FORWARDING_EN for bypassing, otherwise the pipeline interlocks.
module pipeline_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       RegWriteD,
    input  logic       MemWriteD,
    input  logic       ResultSrcD,
    input  logic       BranchD,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] RdD,
    input  logic       ZeroE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       PCSrcE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemWriteM,
    output logic       RegWriteW,
    output logic       ResultSrcW,
    output logic [4:0] RdW
);

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       resultsrc;
        logic       branch;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } e_stage_t;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       resultsrc;
        logic [4:0] rd;
    } m_stage_t;

    typedef struct packed {
        logic       regwrite;
        logic       resultsrc;
        logic [4:0] rd;
    } w_stage_t;

    e_stage_t e_q, e_d;
    m_stage_t m_q, m_d;
    w_stage_t w_q, w_d;
    logic     hazard;

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input m_stage_t m, input w_stage_t w);
        if (m.regwrite && m.rd != 5'd0 && m.rd == rs)
            return 2'b10;
        else if (w.regwrite && w.rd != 5'd0 && w.rd == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Only a load in EX cannot be bypassed in time.
    assign hazard = e_q.resultsrc && e_q.rd != 5'd0 &&
                    (e_q.rd == Rs1D || e_q.rd == Rs2D);
    assign ForwardAE = fwd_sel(e_q.rs1, m_q, w_q);
    assign ForwardBE = fwd_sel(e_q.rs2, m_q, w_q);
`else
    function automatic logic dep(input logic [4:0] rs, input e_stage_t e, input m_stage_t m);
        return rs != 5'd0 && ((e.regwrite && e.rd == rs) || (m.regwrite && m.rd == rs));
    endfunction

    // WB results are written in the first half-cycle, so W never interlocks.
    assign hazard    = dep(Rs1D, e_q, m_q) || dep(Rs2D, e_q, m_q);
    assign ForwardAE = 2'b00;
    assign ForwardBE = 2'b00;

    logic unused_rs;
    assign unused_rs = ^{e_q.rs1, e_q.rs2};
`endif

    always_comb begin
        PCSrcE = e_q.branch & ZeroE;
        StallF = hazard & ~PCSrcE;
        StallD = hazard & ~PCSrcE;
        FlushD = PCSrcE;
        FlushE = hazard | PCSrcE;
    end

    always_comb begin
        e_d = '0;
        if (!FlushE)
            e_d = '{regwrite: RegWriteD, memwrite: MemWriteD, resultsrc: ResultSrcD,
                    branch: BranchD, rd: RdD, rs1: Rs1D, rs2: Rs2D};
        m_d = '{regwrite: e_q.regwrite, memwrite: e_q.memwrite,
                resultsrc: e_q.resultsrc, rd: e_q.rd};
        w_d = '{regwrite: m_q.regwrite, resultsrc: m_q.resultsrc, rd: m_q.rd};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign MemWriteM  = m_q.memwrite;
    assign RegWriteW  = w_q.regwrite;
    assign ResultSrcW = w_q.resultsrc;
    assign RdW        = w_q.rd;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; covers both the FORWARDING_EN and interlock builds.
module tb_pipeline_ctrl;

    logic       clk, rst;
    logic       RegWriteD, MemWriteD, ResultSrcD, BranchD;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       ZeroE;
    logic       StallF, StallD, FlushD, FlushE, PCSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MemWriteM, RegWriteW, ResultSrcW;
    logic [4:0] RdW;

    int checks   = 0;
    int failures = 0;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
        .BranchD(BranchD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .RdW(RdW)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // rw, mw, load, branch, rs1, rs2, rd
    task automatic drive(input logic rw, input logic mw, input logic ld, input logic br,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        RegWriteD  = rw;
        MemWriteD  = mw;
        ResultSrcD = ld;
        BranchD    = br;
        Rs1D       = rs1;
        Rs2D       = rs2;
        RdD        = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        ZeroE = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 5);

        // Reset held: everything must stay zero despite a writing instruction in ID
        repeat (3) tick();
        #1;
        chk("rst_RegWriteW", RegWriteW, 0);
        chk("rst_RdW", RdW, 0);
        chk("rst_ResultSrcW", ResultSrcW, 0);
        chk("rst_MemWriteM", MemWriteM, 0);
        chk("rst_StallF", StallF, 0);
        chk("rst_StallD", StallD, 0);
        chk("rst_FlushD", FlushD, 0);
        chk("rst_FlushE", FlushE, 0);
        chk("rst_PCSrcE", PCSrcE, 0);
        chk("rst_ForwardAE", ForwardAE, 0);
        chk("rst_ForwardBE", ForwardBE, 0);

        rst = 1'b1;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst_rel_e2_RegWriteW", RegWriteW, 0);
        tick();
        chk("rst_rel_e3_RegWriteW", RegWriteW, 1);
        chk("rst_rel_e3_RdW", RdW, 5);
        tick();
        chk("rst_rel_e4_RegWriteW", RegWriteW, 0);

        // Store reaches MEM two edges after leaving ID
        drive(0, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("store_e1_MemWriteM", MemWriteM, 0);
        tick();
        chk("store_e2_MemWriteM", MemWriteM, 1);
        tick();
        chk("store_e3_MemWriteM", MemWriteM, 0);

        // Write to x0 followed by a reader of x0: no stall, no forward
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 11);
        #1;
        chk("x0_StallF", StallF, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("x0_ForwardAE", ForwardAE, 0);
        chk("x0_ForwardBE", ForwardBE, 0);
        repeat (3) tick();

        // Taken branch in EX (also a load writing x5) while ID depends on x5
        drive(1, 0, 1, 1, 0, 0, 5);
        tick();
        ZeroE = 1'b1;
        drive(1, 0, 0, 0, 5, 0, 9);
        #1;
        chk("br_PCSrcE", PCSrcE, 1);
        chk("br_FlushD", FlushD, 1);
        chk("br_FlushE", FlushE, 1);
        chk("br_StallF", StallF, 0);
        chk("br_StallD", StallD, 0);
        tick();
        ZeroE = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("br_after_PCSrcE", PCSrcE, 0);
        tick();
        chk("br_w_RegWriteW", RegWriteW, 1);
        chk("br_w_RdW", RdW, 5);
        tick();
        chk("br_flushed_RegWriteW", RegWriteW, 0);
        chk("br_flushed_RdW", RdW, 0);

        // Branch not taken
        drive(0, 0, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("brnt_PCSrcE", PCSrcE, 0);
        chk("brnt_FlushD", FlushD, 0);
        repeat (3) tick();

        // Reset while a stall is pending discards it
        drive(1, 0, 1, 0, 0, 0, 5);
        tick();
        drive(1, 0, 0, 0, 0, 5, 12);
        #1;
        chk("mr_pre_StallF", StallF, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_in_StallF", StallF, 0);
        chk("mr_in_FlushE", FlushE, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_post_StallD", StallD, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mr_next_StallF", StallF, 0);
        repeat (3) tick();

`ifdef FORWARDING_EN
        // lw x5 ; add x6, x5, x0 -> one stall, then WB forward
        drive(1, 0, 1, 0, 0, 0, 5);
        tick();
        drive(1, 0, 0, 0, 5, 0, 6);
        #1;
        chk("lu_StallF", StallF, 1);
        chk("lu_StallD", StallD, 1);
        chk("lu_FlushE", FlushE, 1);
        chk("lu_FlushD", FlushD, 0);
        tick();
        chk("lu_2_StallF", StallF, 0);
        chk("lu_2_FlushE", FlushE, 0);
        tick();
        drive(1, 0, 0, 0, 1, 6, 7);
        #1;
        chk("lu_ForwardAE", ForwardAE, 1);
        chk("lu_ForwardBE", ForwardBE, 0);
        chk("lu_RdW", RdW, 5);
        chk("lu_ResultSrcW", ResultSrcW, 1);
        chk("sub_StallF", StallF, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sub_ForwardBE", ForwardBE, 2);
        chk("sub_ForwardAE", ForwardAE, 0);

        // Two writers of x8 back to back: MEM wins over WB
        drive(1, 0, 0, 0, 0, 0, 8);
        tick();
        tick();
        drive(1, 0, 0, 0, 8, 8, 13);
        #1;
        chk("prio_StallF", StallF, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("prio_ForwardAE", ForwardAE, 2);
        chk("prio_ForwardBE", ForwardBE, 2);
        repeat (3) tick();
`else
        // add x7 ; dependent -> two interlock cycles, no forwarding
        drive(1, 0, 0, 0, 0, 0, 7);
        tick();
        drive(1, 0, 0, 0, 7, 0, 10);
        #1;
        chk("il1_StallF", StallF, 1);
        chk("il1_StallD", StallD, 1);
        chk("il1_FlushE", FlushE, 1);
        chk("il1_ForwardAE", ForwardAE, 0);
        tick();
        chk("il2_StallF", StallF, 1);
        chk("il2_FlushE", FlushE, 1);
        chk("il2_ForwardBE", ForwardBE, 0);
        tick();
        chk("il3_StallF", StallF, 0);
        chk("il3_FlushE", FlushE, 0);
        chk("il3_RegWriteW", RegWriteW, 1);
        chk("il3_RdW", RdW, 7);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("il4_StallF", StallF, 0);
        chk("il4_RegWriteW", RegWriteW, 0);
        chk("il4_ForwardAE", ForwardAE, 0);
        repeat (3) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
